// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stage-field types and bubble encoding for the control pipeline
package pipe_ctrl_pkg;

  // Widest control word a stage register can carry; narrower words are zero-extended.
  localparam int CTRL_W = 19;

  // Control word held by a stage that carries no instruction.
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
    logic              ds;
  } stage_t;

  // Builds an empty stage around the given bubble word.
  function automatic stage_t bubbleOf(input logic [CTRL_W-1:0] word);
    stage_t s;
    s.ctrl  = word;
    s.valid = 1'b0;
    s.ds    = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// rtl/ctrl_stage_reg.sv - one pipeline stage register with flush, hold and bubble insertion
module ctrl_stage_reg
  import pipe_ctrl_pkg::*;
#(
  parameter logic [CTRL_W-1:0] BUBBLE_WORD = BUBBLE_CTRL
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   fl,
  input  logic   hold,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);

  localparam stage_t BUBBLE_STAGE = bubbleOf(BUBBLE_WORD);

  // Priority: reset, then flush, then hold, then bubble behind a frozen upstream, else load.
  always_ff @(posedge clk) begin
    if (rst || fl) begin
      q <= BUBBLE_STAGE;
    end else if (!hold) begin
      q <= bubble ? BUBBLE_STAGE : d;
    end
  end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// rtl/ctrl_pipe_chain.sv - parametrised decoded-control pipeline with per-stage stall/flush
module ctrl_pipe_chain
  import pipe_ctrl_pkg::*;
#(
  parameter int                STAGES                    = 4,
  parameter int                WIDTH                     = 19,
  parameter int                FLUSH_OLDER_KILLS_YOUNGER = 1,
  parameter logic [WIDTH-1:0]  BUBBLE_VALUE              = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              in_ctrl,
  input  logic                          in_valid,
  input  logic                          in_branch,
  input  logic                          dec_stall,
  input  logic [STAGES-1:0]             stall,
  input  logic [STAGES-1:0]             flush,
  output logic [STAGES*WIDTH-1:0]       out_ctrl,
  output logic [STAGES-1:0]             out_valid,
  output logic [STAGES-1:0]             out_ds,
  output logic                          in_ds,
  output logic [$clog2(STAGES+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(STAGES+1);

  // WIDTH must not exceed CTRL_W; the stage registers hold the word zero-extended.
  localparam logic [CTRL_W-1:0] BUBBLE_EXT = CTRL_W'(BUBBLE_VALUE);

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] fl;
  logic [STAGES-1:0] upFrozen;
  stage_t            stageD [STAGES];
  stage_t            stageQ [STAGES];
  stage_t            entry;
  logic              inDsQ;
  logic [OCC_W-1:0]  occCount;

  // A stalled stage freezes everything upstream: suffix-OR of the stall vector.
  always_comb begin
    hold = stall;
    for (int i = STAGES - 2; i >= 0; i--) begin
      hold[i] = stall[i] | hold[i+1];
    end
  end

  // A flush optionally kills every younger stage as well: suffix-OR of the flush vector.
  always_comb begin
    fl = flush;
    if (FLUSH_OLDER_KILLS_YOUNGER != 0) begin
      for (int i = STAGES - 2; i >= 0; i--) begin
        fl[i] = flush[i] | fl[i+1];
      end
    end
  end

  // Decode entry word; an invalid decode slot enters as the bubble word so empty stages stay clean.
  always_comb begin
    entry       = bubbleOf(BUBBLE_EXT);
    entry.valid = in_valid;
    entry.ds    = inDsQ;
    if (in_valid) begin
      entry.ctrl               = '0;
      entry.ctrl[WIDTH-1:0]    = in_ctrl;
    end
  end

  genvar i;
  generate
    for (i = 0; i < STAGES; i++) begin : gStage
      if (i == 0) begin : gHead
        assign stageD[i]   = entry;
        assign upFrozen[i] = dec_stall;
      end else begin : gBody
        assign stageD[i]   = stageQ[i-1];
        assign upFrozen[i] = hold[i-1];
      end

      ctrl_stage_reg #(
        .BUBBLE_WORD(BUBBLE_EXT)
      ) uStage (
        .clk   (clk),
        .rst   (rst),
        .fl    (fl[i]),
        .hold  (hold[i]),
        .bubble(upFrozen[i]),
        .d     (stageD[i]),
        .q     (stageQ[i])
      );

      assign out_ctrl[i*WIDTH +: WIDTH] = stageQ[i].ctrl[WIDTH-1:0];
      assign out_valid[i]               = stageQ[i].valid;
      assign out_ds[i]                  = stageQ[i].ds;
    end
  endgenerate

  // Delay-slot flag advances only with decode, so a branch held in decode still tags its successor.
  always_ff @(posedge clk) begin
    if (rst || fl[0]) begin
      inDsQ <= 1'b0;
    end else if (!dec_stall && !hold[0]) begin
      inDsQ <= in_valid & in_branch;
    end
  end

  assign in_ds = inDsQ;

  // Population count of the per-stage valid bits.
  always_comb begin
    occCount = '0;
    for (int k = 0; k < STAGES; k++) begin
      occCount = occCount + OCC_W'(out_valid[k]);
    end
  end

  assign occupancy = occCount;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb/tb_ctrl_pipe_chain.sv - directed self-checking bench for ctrl_pipe_chain
module tb_ctrl_pipe_chain;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] in_ctrl;
  logic        in_valid;
  logic        in_branch;
  logic        dec_stall;
  logic [3:0]  stall;
  logic [3:0]  flush;
  logic [75:0] out_ctrl;
  logic [3:0]  out_valid;
  logic [3:0]  out_ds;
  logic        in_ds;
  logic [2:0]  occupancy;

  int vectors = 0;
  int miscompares = 0;

  ctrl_pipe_chain #(
    .STAGES(4),
    .WIDTH(19),
    .FLUSH_OLDER_KILLS_YOUNGER(1),
    .BUBBLE_VALUE(19'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_ctrl(in_ctrl),
    .in_valid(in_valid),
    .in_branch(in_branch),
    .dec_stall(dec_stall),
    .stall(stall),
    .flush(flush),
    .out_ctrl(out_ctrl),
    .out_valid(out_valid),
    .out_ds(out_ds),
    .in_ds(in_ds),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [75:0] w4(input logic [18:0] s3, input logic [18:0] s2,
                                     input logic [18:0] s1, input logic [18:0] s0);
    return {s3, s2, s1, s0};
  endfunction

  initial begin
    rst = 1'b1; in_ctrl = '0; in_valid = 1'b0; in_branch = 1'b0;
    dec_stall = 1'b0; stall = '0; flush = '0;
    tick();
    chk("reset_valid", out_valid, 4'b0000);
    chk("reset_ds", out_ds, 4'b0000);
    chk("reset_in_ds", in_ds, 1'b0);
    chk("reset_occ", occupancy, 3'd0);
    chk("reset_ctrl", out_ctrl, w4(0, 0, 0, 0));

    // free flow
    rst = 1'b0; in_valid = 1'b1; in_ctrl = 19'h1;
    tick();
    chk("flow_s0", out_ctrl, w4(0, 0, 0, 19'h1));
    chk("flow_occ1", occupancy, 3'd1);
    in_ctrl = 19'h2; tick();
    in_ctrl = 19'h3; tick();
    chk("flow_occ3", occupancy, 3'd3);
    chk("flow_valid3", out_valid, 4'b0111);
    in_ctrl = 19'h4; tick();
    chk("flow_full_ctrl", out_ctrl, w4(19'h1, 19'h2, 19'h3, 19'h4));
    chk("flow_full_valid", out_valid, 4'b1111);
    chk("flow_occ4", occupancy, 3'd4);

    // stall at stage 2 for two cycles
    in_ctrl = 19'h5; stall = 4'b0100;
    tick();
    chk("stall1_ctrl", out_ctrl, w4(0, 19'h2, 19'h3, 19'h4));
    chk("stall1_valid", out_valid, 4'b0111);
    chk("stall1_occ", occupancy, 3'd3);
    tick();
    chk("stall2_ctrl", out_ctrl, w4(0, 19'h2, 19'h3, 19'h4));
    stall = 4'b0000;
    tick();
    chk("unstall_ctrl", out_ctrl, w4(19'h2, 19'h3, 19'h4, 19'h5));
    chk("unstall_valid", out_valid, 4'b1111);

    // flush[2] with stall[0] in the same cycle
    in_ctrl = 19'h6; flush = 4'b0100; stall = 4'b0001;
    tick();
    chk("flush_ctrl", out_ctrl, w4(19'h3, 0, 0, 0));
    chk("flush_valid", out_valid, 4'b1000);
    chk("flush_occ", occupancy, 3'd1);
    chk("flush_in_ds", in_ds, 1'b0);

    // invalid decode slot enters as a clean bubble
    flush = '0; stall = '0; in_valid = 1'b0; in_ctrl = 19'h7ABCD;
    tick();
    chk("invalid_ctrl", out_ctrl, w4(0, 0, 0, 0));
    chk("invalid_occ", occupancy, 3'd0);

    // branch held in decode for three cycles
    in_valid = 1'b1; in_branch = 1'b1; in_ctrl = 19'h100; dec_stall = 1'b1;
    tick(); tick(); tick();
    chk("dsstall_in_ds", in_ds, 1'b0);
    chk("dsstall_valid", out_valid, 4'b0000);
    chk("dsstall_ctrl", out_ctrl, w4(0, 0, 0, 0));
    dec_stall = 1'b0;
    tick();
    chk("branch_in_ds", in_ds, 1'b1);
    chk("branch_ds", out_ds, 4'b0000);
    chk("branch_ctrl", out_ctrl, w4(0, 0, 0, 19'h100));
    in_branch = 1'b0; in_ctrl = 19'h200;
    tick();
    chk("slot_ds", out_ds, 4'b0001);
    chk("slot_in_ds", in_ds, 1'b0);
    in_ctrl = 19'h300;
    tick();
    chk("after_slot_ds", out_ds, 4'b0010);
    chk("after_slot_ctrl", out_ctrl, w4(0, 19'h100, 19'h200, 19'h300));
    chk("after_slot_occ", occupancy, 3'd3);

    // decode stalled: bubbles enter stage 0 while older words drain
    dec_stall = 1'b1; in_ctrl = 19'h400;
    tick();
    chk("drain1_ctrl", out_ctrl, w4(19'h100, 19'h200, 19'h300, 0));
    chk("drain1_valid", out_valid, 4'b1110);
    chk("drain1_ds", out_ds, 4'b0100);
    tick();
    chk("drain2_ctrl", out_ctrl, w4(19'h200, 19'h300, 0, 0));
    chk("drain2_valid", out_valid, 4'b1100);
    chk("drain2_ds", out_ds, 4'b1000);
    chk("drain2_in_ds", in_ds, 1'b0);

    // refill with branches, then synchronous reset under a stall
    dec_stall = 1'b0; in_branch = 1'b1; in_valid = 1'b1;
    in_ctrl = 19'h11; tick();
    in_ctrl = 19'h22; tick();
    in_ctrl = 19'h33; tick();
    in_ctrl = 19'h44; tick();
    chk("refill_ctrl", out_ctrl, w4(19'h11, 19'h22, 19'h33, 19'h44));
    chk("refill_ds", out_ds, 4'b0111);
    chk("refill_in_ds", in_ds, 1'b1);
    rst = 1'b1; stall = 4'b0010;
    #2;
    chk("prerst_valid", out_valid, 4'b1111);
    chk("prerst_in_ds", in_ds, 1'b1);
    tick();
    chk("rst_valid", out_valid, 4'b0000);
    chk("rst_ds", out_ds, 4'b0000);
    chk("rst_in_ds", in_ds, 1'b0);
    chk("rst_occ", occupancy, 3'd0);
    chk("rst_ctrl", out_ctrl, w4(0, 0, 0, 0));

    // flush and stall on the same stage: flush wins
    rst = 1'b0; stall = '0; in_branch = 1'b0; in_ctrl = 19'h55;
    tick();
    chk("pre_fs_ctrl", out_ctrl, w4(0, 0, 0, 19'h55));
    flush = 4'b0001; stall = 4'b0001; in_ctrl = 19'h66;
    tick();
    chk("fs_valid", out_valid, 4'b0000);
    chk("fs_ctrl", out_ctrl, w4(0, 0, 0, 0));
    flush = '0; stall = '0;
    tick();
    chk("post_fs_ctrl", out_ctrl, w4(0, 0, 0, 19'h66));
    chk("post_fs_valid", out_valid, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
